// File: rtl/psa_reduce_seq.sv
// Sequential sub-word reduction: folds the signed lanes of two packed operands into one
// sign-extended scalar, adding one lane pair per cycle behind valid/ready handshakes.
module psa_reduce_seq #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Result,
  output logic              busy
);

  localparam int ACC_W = LANE_W + 1 + $clog2(LANES);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RED_W = LANES * LANE_W;

  generate
    if (RED_W > DATA_W) begin : g_bad_cfg
      $error("psa_reduce_seq: LANES*LANE_W exceeds DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_q;
  logic [RED_W-1:0]   a_q;
  logic [RED_W-1:0]   b_q;
  logic [DATA_W-1:0]  result_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;

  logic [LANE_W-1:0]  lane_a_s;
  logic [LANE_W-1:0]  lane_b_s;
  logic [ACC_W-1:0]   acc_d;
  logic               last_lane_s;

  // Lane pair selected by the index, widened so the running sum cannot overflow.
  always_comb begin
    lane_a_s    = a_q[idx_q*LANE_W +: LANE_W];
    lane_b_s    = b_q[idx_q*LANE_W +: LANE_W];
    acc_d       = acc_q + ACC_W'($signed(lane_a_s)) + ACC_W'($signed(lane_b_s));
    last_lane_s = (idx_q == IDX_W'(LANES - 1));
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= A[RED_W-1:0];
            b_q        <= B[RED_W-1:0];
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (last_lane_s) begin
            result_q    <= DATA_W'($signed(acc_d));
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q     <= S_ACCUM;
          end
        end
        S_DONE: begin
          // Result stays put after the handshake until the next operation completes.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q     <= S_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_psa_reduce_seq.sv
// Randomised and directed bench for psa_reduce_seq against a lane-sum reference model.
module tb_psa_reduce_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  psa_reduce_seq #(.DATA_W(16), .LANE_W(4), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum of all eight signed nibbles, truncated to 16 bits.
  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    int s;
    logic [3:0] na;
    logic [3:0] nb;
    int va;
    int vb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      na = a[i*4 +: 4];
      nb = b[i*4 +: 4];
      va = $signed(na);
      vb = $signed(nb);
      s = s + va + vb;
    end
    return s[15:0];
  endfunction

  // Issues one operation from IDLE, scrambles the inputs after acceptance, holds
  // backpressure for 'hold' cycles, then completes the handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] res, output int lat, output bit stable,
                        output logic ov_after, output logic ir_after);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Result;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || Result !== res) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ov_after = out_valid;
    ir_after = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 16'h0000; B = 16'h0000;
    #12;
    tests_run++;
    if (out_valid !== 1'b0 || Result !== 16'h0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: out_valid=%b Result=%h busy=%b, need 0/0000/0", out_valid, Result, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b busy=%b, need 1/0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [15:0] da [4];
    logic [15:0] db [4];
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    bit stable;
    logic ov, ir;
    da[0] = 16'h1111; db[0] = 16'h1111;
    da[1] = 16'h8888; db[1] = 16'h8888;
    da[2] = 16'h7777; db[2] = 16'h7777;
    da[3] = 16'h7F80; db[3] = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      exp = ref_sum(da[k], db[k]);
      run_op(da[k], db[k], 0, res, lat, stable, ov, ir);
      tests_run++;
      if (lat !== 4) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d edges, need 4", k, lat);
      end
      tests_run++;
      if (res !== exp) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got %h, need %h", k, res, exp);
      end
      tests_run++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_handshake[%0d]: out_valid=%b in_ready=%b, need 0/1", k, ov, ir);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b, res;
    int lat;
    bit stable;
    logic ov, ir;
    a = 16'h3A5C; b = 16'hC1E7;
    run_op(a, b, 5, res, lat, stable, ov, ir);
    tests_run++;
    if (res !== ref_sum(a, b)) begin
      tests_failed++;
      $display("FAIL bp_result: got %h, need %h", res, ref_sum(a, b));
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_stable: stable=%b, need 1", stable);
    end
    tests_run++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, need 1/0", ir, ov);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [15:0] a1, b1;
    int lat;
    a1 = 16'h2468; b1 = 16'h9BDF;
    A = a1; B = b1; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 16'h7777; B = 16'h7777;
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_busy: in_ready=%b busy=%b, need 0/1", in_ready, busy);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      A = 16'($urandom); B = 16'($urandom);
      lat++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (Result !== ref_sum(a1, b1) || lat !== 4) begin
      tests_failed++;
      $display("FAIL ignore_result: got %h after %0d edges, need %h after 4", Result, lat, ref_sum(a1, b1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [15:0] a, b, res;
    int lat;
    bit stable;
    logic ov, ir;
    run_op(16'h1111, 16'h1111, 0, res, lat, stable, ov, ir);
    tests_run++;
    if (res !== 16'h0008) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %h, need 0008", res);
    end
    A = 16'h5555; B = 16'h5555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || Result !== 16'h0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: out_valid=%b Result=%h busy=%b, need 0/0000/0", out_valid, Result, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    a = 16'($urandom); b = 16'($urandom);
    run_op(a, b, 0, res, lat, stable, ov, ir);
    tests_run++;
    if (res !== ref_sum(a, b) || lat !== 4) begin
      tests_failed++;
      $display("FAIL midrst_next: got %h after %0d edges, need %h after 4", res, lat, ref_sum(a, b));
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, res;
    int lat;
    bit stable;
    logic ov, ir;
    int hold;
    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      hold = $urandom_range(0, 3);
      run_op(a, b, hold, res, lat, stable, ov, ir);
      tests_run++;
      if (res !== ref_sum(a, b) || lat !== 4 || stable !== 1'b1 || ir !== 1'b1) begin
        tests_failed++;
        $display("FAIL random[%0d]: A=%h B=%h got %h lat=%0d stable=%b in_ready=%b, need %h lat=4 stable=1 in_ready=1",
                 n, a, b, res, lat, stable, ir, ref_sum(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] a, b, exp;
    int accepts, got, cyc, last_acc;
    accepts = 0; got = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    while (got < 8 && cyc < 300) begin
      if (out_valid === 1'b1) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (Result !== exp) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d]: got %h, need %h", got, Result, exp);
        end
        got++;
      end
      if (in_ready === 1'b1 && accepts < 8) begin
        a = 16'($urandom); b = 16'($urandom);
        A = a; B = b; in_valid = 1'b1;
        exp_q.push_back(ref_sum(a, b));
        if (last_acc >= 0) begin
          tests_run++;
          if (cyc - last_acc !== 6) begin
            tests_failed++;
            $display("FAIL b2b_interval: got %0d cycles, need 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (got !== 8) begin
      tests_failed++;
      $display("FAIL b2b_timeout: got %0d results, need 8", got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_inputs();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
